// File: rtl/quickq_pkg.sv
// ----------------------------------------------------------------------------
// quickq_pkg
// Shared definitions for the QuickQ sorted-array stage controller:
//   qq_ctrl_state_t : walk sequencer states
//   QQ_MODE_*       : valueRouter mode encodings
//   QQ_EMPTY_VAL    : sentinel marking an unoccupied slot
// ----------------------------------------------------------------------------
package quickq_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CMP  = 3'd2,
        BUMP = 3'd3,
        PUSH = 3'd4
    } qq_ctrl_state_t;

    localparam logic [1:0]  QQ_MODE_CMP  = 2'b00;
    localparam logic [1:0]  QQ_MODE_BUMP = 2'b01;

    localparam logic [31:0] QQ_EMPTY_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/quickq_stage_ctrl.sv
// ----------------------------------------------------------------------------
// quickq_stage_ctrl
// Sequencer for one QuickQ sorted-array stage. An accepted value is carried
// through a read/compare/write-back walk over the occupied BRAM entries using
// the external valueRouter (min stays in the slot, max is carried on). At the
// end of the walk the carried value is either appended (count bump) or, when
// the stage is full, the displaced largest value is offered downstream.
//
// Ports:
//   clk, rst_n            stage clock, asynchronous active-low reset
//   in_valid/in_data/
//   in_ready              upstream value handshake
//   out_valid/out_data/
//   out_ready             displaced value handshake to downstream stage
//   clr                   empty-stage command, honoured only in IDLE
//   bram_*                single-port BRAM interface (1-cycle read latency)
//   rt_*                  valueRouter interface
//   count                 occupied entries
//   busy                  high whenever not IDLE
// ----------------------------------------------------------------------------
module quickq_stage_ctrl
    import quickq_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                ARRAY_SIZE = 5,
    parameter int                ADDR_W     = 8,
    parameter logic [DATA_W-1:0] EMPTY_VAL  = QQ_EMPTY_VAL
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,

    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,

    input  logic              clr,

    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,

    output logic [DATA_W-1:0] rt_bram_out,
    output logic [DATA_W-1:0] rt_reg_out,
    output logic [1:0]        rt_mode,
    output logic [7:0]        rt_array_size,
    output logic [7:0]        rt_array_cnt_in,
    input  logic [DATA_W-1:0] rt_bram_insert,
    input  logic [DATA_W-1:0] rt_to_register,
    input  logic [7:0]        rt_array_cnt_out,
    input  logic              rt_full,

    output logic [7:0]        count,
    output logic              busy
);

    localparam logic [7:0] SIZE_U8  = 8'(ARRAY_SIZE);
    localparam logic [7:0] LAST_IDX = 8'(ARRAY_SIZE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    qq_ctrl_state_t    state_q,     state_d;
    logic [7:0]        count_q,     count_d;
    logic [DATA_W-1:0] carry_q,     carry_d;
    logic [7:0]        idx_q,       idx_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        rt_mode_q,   rt_mode_d;
    logic              bram_en_q,   bram_en_d;
    logic              bram_we_q,   bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;

    logic              full;

    assign full = (count_q == SIZE_U8);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (clr) begin
                    // clr takes priority; in_ready is low so nothing is accepted
                    count_d = '0;
                end else if (in_valid && (in_data != EMPTY_VAL)) begin
                    // A sentinel value is accepted but dropped: it would
                    // otherwise be indistinguishable from an empty slot.
                    carry_d = in_data;
                    idx_d   = '0;
                    state_d = RD;
                end
            end

            RD: begin
                state_d = CMP;
            end

            CMP: begin
                carry_d = rt_to_register;
                if (!full && (idx_q == count_q)) begin
                    // Just wrote the carried value into the first free slot
                    state_d = BUMP;
                end else if (full && (idx_q == LAST_IDX)) begin
                    // Every slot visited; the carry is now the displaced max
                    state_d     = PUSH;
                    out_valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = RD;
                end
            end

            BUMP: begin
                count_d = rt_array_cnt_out;
                carry_d = EMPTY_VAL;
                state_d = IDLE;
            end

            PUSH: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    carry_d     = EMPTY_VAL;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up
        // with the state they belong to without a decode stage.
        bram_en_d   = (state_d == RD) || (state_d == CMP);
        bram_we_d   = (state_d == CMP);
        bram_addr_d = ADDR_W'(idx_d);
        rt_mode_d   = (state_d == BUMP) ? QQ_MODE_BUMP : QQ_MODE_CMP;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            carry_q     <= EMPTY_VAL;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            rt_mode_q   <= QQ_MODE_CMP;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            rt_mode_q   <= rt_mode_d;
            bram_en_q   <= bram_en_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE) && !clr;
    assign busy      = (state_q != IDLE);
    assign count     = count_q;

    // carry_q only changes on the PUSH handshake, so out_data is stable
    // for the whole time out_valid is held against a stalled downstream.
    assign out_valid = out_valid_q;
    assign out_data  = carry_q;

    assign bram_en    = bram_en_q;
    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    // Write data comes straight from the router: it is only meaningful in
    // CMP, the single state in which bram_we is asserted.
    assign bram_wdata = rt_bram_insert;

    assign rt_reg_out      = carry_q;
    assign rt_mode         = rt_mode_q;
    assign rt_array_size   = SIZE_U8;
    assign rt_array_cnt_in = count_q;

    // The slot at idx==count has never been written since the last clear
    // (or holds a stale value), so present it as empty to the router.
    always_comb begin
        rt_bram_out = EMPTY_VAL;
        if ((state_q == CMP) && (idx_q != count_q)) begin
            rt_bram_out = bram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Assertions
    // ------------------------------------------------------------------
    a_full_agrees : assert property (
        @(posedge clk) disable iff (!rst_n)
        ((state_q == CMP) || (state_q == BUMP)) |-> (rt_full == full)
    );

    a_count_bound : assert property (
        @(posedge clk) disable iff (!rst_n)
        (count_q <= SIZE_U8)
    );

endmodule

// File: tb/tb_quickq_stage_ctrl.sv
// ----------------------------------------------------------------------------
// tb_quickq_stage_ctrl
// Bench for quickq_stage_ctrl with a BRAM model, a behavioural valueRouter
// and a sorted-queue reference model of the stage contents.
// ----------------------------------------------------------------------------
module tb_quickq_stage_ctrl;

    localparam int          N     = 5;
    localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        clr;
    logic        bram_en;
    logic        bram_we;
    logic [7:0]  bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;
    logic [31:0] rt_bram_out;
    logic [31:0] rt_reg_out;
    logic [1:0]  rt_mode;
    logic [7:0]  rt_array_size;
    logic [7:0]  rt_array_cnt_in;
    logic [31:0] rt_bram_insert;
    logic [31:0] rt_to_register;
    logic [7:0]  rt_array_cnt_out;
    logic        rt_full;
    logic [7:0]  count;
    logic        busy;

    int total = 0;
    int bad   = 0;

    quickq_stage_ctrl #(
        .DATA_W     (32),
        .ARRAY_SIZE (N),
        .ADDR_W     (8),
        .EMPTY_VAL  (EMPTY)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_ready        (out_ready),
        .clr              (clr),
        .bram_en          (bram_en),
        .bram_we          (bram_we),
        .bram_addr        (bram_addr),
        .bram_wdata       (bram_wdata),
        .bram_rdata       (bram_rdata),
        .rt_bram_out      (rt_bram_out),
        .rt_reg_out       (rt_reg_out),
        .rt_mode          (rt_mode),
        .rt_array_size    (rt_array_size),
        .rt_array_cnt_in  (rt_array_cnt_in),
        .rt_bram_insert   (rt_bram_insert),
        .rt_to_register   (rt_to_register),
        .rt_array_cnt_out (rt_array_cnt_out),
        .rt_full          (rt_full),
        .count            (count),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read, write when enabled
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            bram_rdata <= mem[bram_addr];
        end
    end

    // valueRouter model: smaller stays, larger carries on
    assign rt_bram_insert   = (rt_bram_out < rt_reg_out) ? rt_bram_out : rt_reg_out;
    assign rt_to_register   = (rt_bram_out < rt_reg_out) ? rt_reg_out  : rt_bram_out;
    assign rt_array_cnt_out = (rt_mode == 2'b01) ? rt_array_cnt_in + 8'd1 : rt_array_cnt_in;
    assign rt_full          = (rt_array_cnt_in == rt_array_size);

    // Observed writes and downstream handshakes, sampled mid-cycle
    logic [7:0]  wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] push_q    [$];
    always @(negedge clk) begin
        if (bram_en && bram_we) begin
            wr_addr_q.push_back(bram_addr);
            wr_data_q.push_back(bram_wdata);
        end
        if (out_valid && out_ready) push_q.push_back(out_data);
    end

    // Reference model: stage contents as an ascending queue
    logic [31:0] model [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_clr();
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd5;
        #1;
        chk("clr_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_busy", busy, 1'b0);
        model.delete();
        $display("clr: count=%0d", count);
    endtask

    task automatic do_insert(input logic [31:0] v, input int stall, input bit rnd_clr);
        logic [31:0] nv [$];
        int          c, p, guard, busy_cyc, stall_seen, stall_err, nw;
        bit          full;
        logic [31:0] first_out;

        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_wait", in_ready, 1'b1);
        wr_addr_q.delete();
        wr_data_q.delete();
        push_q.delete();
        c    = model.size();
        full = (c == N);

        in_valid  = 1'b1;
        in_data   = v;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid  = 1'b0;

        if (v == EMPTY) begin
            chk("drop_busy", busy, 1'b0);
            @(posedge clk); #1;
            chk("drop_writes", wr_addr_q.size(), 0);
            chk("drop_count", count, c);
            out_ready = 1'b1;
            $display("insert empty: dropped count=%0d", count);
            return;
        end

        busy_cyc   = 0;
        stall_seen = 0;
        stall_err  = 0;
        first_out  = '0;
        while (busy && busy_cyc < 2000) begin
            busy_cyc++;
            if (out_valid && !out_ready) begin
                if (stall_seen == 0) first_out = out_data;
                else if (out_data !== first_out) stall_err++;
                if (in_ready) stall_err++;
                stall_seen++;
                if (stall_seen > stall) out_ready = 1'b1;
            end
            // clr while busy must have no effect
            if (rnd_clr) clr = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        clr       = 1'b0;
        out_ready = 1'b1;
        chk("walk_done", busy, 1'b0);

        // Expected contents after inserting v into the sorted stage
        nv = model;
        p  = nv.size();
        for (int i = 0; i < nv.size(); i++) begin
            if (nv[i] > v) begin
                p = i;
                break;
            end
        end
        nv.insert(p, v);
        nw = full ? N : c + 1;

        chk("write_count", wr_addr_q.size(), nw);
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            chk("write_addr", wr_addr_q[i], i);
            chk("write_data", wr_data_q[i], nv[i]);
        end

        if (full) begin
            chk("push_count", push_q.size(), 1);
            if (push_q.size() > 0) chk("push_data", push_q[0], nv[N]);
            void'(nv.pop_back());
            chk("latency_full", busy_cyc, 2 * N + 1 + stall);
            if (stall > 0) begin
                chk("stall_stable", stall_err, 0);
                chk("stall_cycles", stall_seen, stall + 1);
            end
        end else begin
            chk("push_none", push_q.size(), 0);
            // cycles from the accept cycle up to the first IDLE cycle
            chk("latency", busy_cyc + 1, 2 * (c + 1) + 2);
        end
        model = nv;
        chk("count", count, model.size());
        $display("insert %0d: count=%0d writes=%0d pushes=%0d busy=%0d",
                 v, count, wr_addr_q.size(), push_q.size(), busy_cyc);
    endtask

    // Directed vectors
    typedef struct {
        int          op;        // 0 insert, 1 clr with in_valid
        logic [31:0] data;
        int          stall;
        int          exp_count;
        bit          exp_push;
        logic [31:0] exp_push_data;
        logic [4:0][31:0] exp_mem;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input int op, input logic [31:0] data, input int stall,
                           input int cnt, input bit push, input logic [31:0] pd,
                           input logic [31:0] m0, input logic [31:0] m1,
                           input logic [31:0] m2, input logic [31:0] m3,
                           input logic [31:0] m4);
        vec_t v;
        v.op            = op;
        v.data          = data;
        v.stall         = stall;
        v.exp_count     = cnt;
        v.exp_push      = push;
        v.exp_push_data = pd;
        v.exp_mem[0]    = m0;
        v.exp_mem[1]    = m1;
        v.exp_mem[2]    = m2;
        v.exp_mem[3]    = m3;
        v.exp_mem[4]    = m4;
        tbl.push_back(v);
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        clr       = 1'b0;

        add_vec(0, 32'd2, 0, 1, 0, 0, 2, 0, 0, 0, 0);
        add_vec(0, 32'd7, 0, 2, 0, 0, 2, 7, 0, 0, 0);
        add_vec(0, 32'd1, 0, 3, 0, 0, 1, 2, 7, 0, 0);
        add_vec(0, 32'd4, 0, 4, 0, 0, 1, 2, 4, 7, 0);
        add_vec(0, 32'd9, 0, 5, 0, 0, 1, 2, 4, 7, 9);
        add_vec(0, 32'd3, 0, 5, 1, 9, 1, 2, 3, 4, 7);
        add_vec(1, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add_vec(0, 32'd9, 0, 1, 0, 0, 9, 0, 0, 0, 0);
        add_vec(0, 32'd4, 0, 2, 0, 0, 4, 9, 0, 0, 0);
        add_vec(0, 32'd1, 0, 3, 0, 0, 1, 4, 9, 0, 0);
        add_vec(0, 32'd7, 0, 4, 0, 0, 1, 4, 7, 9, 0);
        add_vec(0, 32'd2, 0, 5, 0, 0, 1, 2, 4, 7, 9);
        add_vec(0, 32'd3, 6, 5, 1, 9, 1, 2, 3, 4, 7);
        add_vec(0, EMPTY, 0, 5, 0, 0, 1, 2, 3, 4, 7);

        repeat (3) @(posedge clk);
        #1;
        // reset state while still in reset
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_bram_en", bram_en, 1'b0);
        chk("rst_bram_we", bram_we, 1'b0);
        chk("rst_rt_mode", rt_mode, 2'b00);
        chk("rst_carry", rt_reg_out, EMPTY);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("array_size", rt_array_size, N);

        foreach (tbl[k]) begin
            if (tbl[k].op == 1) begin
                do_clr();
                chk("tbl_count", count, tbl[k].exp_count);
            end else begin
                do_insert(tbl[k].data, tbl[k].stall, 1'b0);
                chk("tbl_count", count, tbl[k].exp_count);
                if (tbl[k].data != EMPTY) begin
                    chk("tbl_push", push_q.size(), tbl[k].exp_push);
                    if (tbl[k].exp_push && push_q.size() > 0)
                        chk("tbl_push_data", push_q[0], tbl[k].exp_push_data);
                end
                for (int i = 0; i < tbl[k].exp_count; i++)
                    chk("tbl_mem", mem[i], tbl[k].exp_mem[i]);
            end
        end

        // Asynchronous reset in the middle of a full-stage walk
        in_valid  = 1'b1;
        in_data   = 32'd6;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (!bram_we && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("reach_cmp", bram_we, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("abort_busy", busy, 1'b0);
        chk("abort_count", count, 0);
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_bram_en", bram_en, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model.delete();
        $display("reset mid-walk: count=%0d", count);
        do_insert(32'd5, 0, 1'b0);
        chk("post_reset_mem0", mem[0], 32'd5);
        chk("post_reset_count", count, 1);

        // Randomized operations against the reference model
        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) do_clr();
            else if (r == 1) do_insert(EMPTY, 0, 1'b0);
            else do_insert($urandom_range(0, 40), $urandom_range(0, 3), 1'b1);
            for (int i = 0; i < model.size(); i++)
                chk("rand_mem", mem[i], model[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
